// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader and its memory sizing.
// Pure declarations: no latency and no flow-control behaviour of its own.
package imem_loader_pkg;

    localparam int LEN_W      = 16;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DEPTH  = 256;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN0  = 3'd1,
        LEN1  = 3'd2,
        DATA  = 3'd3,
        CSUM  = 3'd4,
        DONE  = 3'd5,
        ERROR = 3'd6
    } state_t;

endpackage

// File: rtl/word_packer.sv
// Packs four bytes, first byte in bits 7:0, into one 32-bit word.
// The word and its one-cycle pulse are registered on the 4th byte's edge; it never stalls its source.
module word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic [1:0]  byte_idx,
    output logic        word_vld,
    output logic [31:0] word_dat
);

    logic [23:0] low_bytes;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_idx  <= 2'd0;
            low_bytes <= 24'd0;
            word_vld  <= 1'b0;
            word_dat  <= 32'd0;
        end else begin
            word_vld <= 1'b0;
            if (clear) begin
                byte_idx <= 2'd0;
            end else if (byte_vld) begin
                if (byte_idx == 2'd3) begin
                    word_dat <= {byte_dat, low_bytes};
                    word_vld <= 1'b1;
                    byte_idx <= 2'd0;
                end else begin
                    // Shift right so earlier bytes settle into the low lanes.
                    low_bytes <= {byte_dat, low_bytes[23:8]};
                    byte_idx  <= byte_idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length/data/checksum byte frame into instruction memory writes and releases the CPU on success.
// Memory write appears the cycle after a word's 4th byte; rx_ready never drops inside a frame.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    state_t           state, state_nxt;
    logic [7:0]       len_lo;
    logic [LEN_W-1:0] len;
    logic [7:0]       csum;
    logic [1:0]       byte_idx;
    logic             xfer;
    logic             start_go;
    logic             word_done;
    logic             last_word;
    logic [LEN_W-1:0] len_full;

    assign rx_ready  = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
    assign xfer      = rx_valid && rx_ready;
    assign start_go  = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign word_done = xfer && (state == DATA) && (byte_idx == 2'd3);
    assign len_full  = {rx_data, len_lo};
    assign last_word = (LEN_W'(words_loaded) + 16'd1) == len;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE, ERROR: if (start) state_nxt = LEN0;
            LEN0:              if (xfer) state_nxt = LEN1;
            LEN1: begin
                if (xfer) begin
                    if ((len_full == '0) || (len_full > LEN_W'(DEPTH))) state_nxt = ERROR;
                    else                                                state_nxt = DATA;
                end
            end
            DATA:              if (word_done && last_word) state_nxt = CSUM;
            CSUM: begin
                if (xfer) state_nxt = (rx_data == csum) ? DONE : ERROR;
            end
            default:           state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_hold     <= 1'b1;
            len_lo       <= 8'd0;
            len          <= '0;
            csum         <= 8'd0;
            words_loaded <= '0;
            mem_addr     <= '0;
        end else begin
            // Status flags follow the state being entered so they line up with it.
            busy     <= (state_nxt == LEN0) || (state_nxt == LEN1) ||
                        (state_nxt == DATA) || (state_nxt == CSUM);
            done     <= (state_nxt == DONE);
            error    <= (state_nxt == ERROR);
            cpu_hold <= (state_nxt != DONE);
            if (start_go) begin
                words_loaded <= '0;
                csum         <= 8'd0;
                len          <= '0;
            end
            if (xfer && (state == LEN0)) begin
                len_lo <= rx_data;
                csum   <= csum ^ rx_data;
            end
            if (xfer && (state == LEN1)) begin
                len  <= len_full;
                csum <= csum ^ rx_data;
            end
            if (xfer && (state == DATA)) csum <= csum ^ rx_data;
            if (word_done) begin
                mem_addr     <= words_loaded[ADDR_W-1:0];
                words_loaded <= words_loaded + 1'b1;
            end
        end
    end

    word_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (start_go),
        .byte_vld (xfer && (state == DATA)),
        .byte_dat (rx_data),
        .byte_idx (byte_idx),
        .word_vld (mem_we),
        .word_dat (mem_wdata)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard drained by an independent monitor.
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef logic [7:0] bq_t[$];

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_cmp = 0;
    int  n_bad = 0;

    bq_t good_fr  = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC2};
    bq_t bad_fr   = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC3};
    bq_t zero_fr  = '{8'h00, 8'h00};
    bq_t big_fr   = '{8'h01, 8'h01};
    bq_t one_fr   = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h02};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Write monitor: every mem_we must match the oldest expected write.
    always @(negedge clk) begin
        if (reset && mem_we) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: addr %h data %h, expected no write", mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", {24'd0, mem_addr}, {24'd0, mon_e.addr});
                check("wr_data", mem_wdata, mon_e.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (!rx_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            check("rdy_timeout", {31'd0, rx_ready}, 32'd1);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_range(input bq_t fr, input int from, input int to, input int max_gap);
        for (int i = from; i <= to; i++)
            send_byte(fr[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        check({tag, "_mem_we"},   {31'd0, mem_we},   32'd0);
        check({tag, "_busy"},     {31'd0, busy},     32'd0);
        check({tag, "_done"},     {31'd0, done},     32'd0);
        check({tag, "_error"},    {31'd0, error},    32'd0);
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
        check({tag, "_words"},    {23'd0, words_loaded}, 32'd0);
        check({tag, "_addr"},     {24'd0, mem_addr}, 32'd0);
        check({tag, "_wdata"},    mem_wdata, 32'd0);
    endtask

    task automatic check_status(input string tag, input logic d, input logic e,
                                input logic h, input int w);
        @(negedge clk);
        check({tag, "_done"},     {31'd0, done},     {31'd0, d});
        check({tag, "_error"},    {31'd0, error},    {31'd0, e});
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, h});
        check({tag, "_busy"},     {31'd0, busy},     32'd0);
        check({tag, "_words"},    {23'd0, words_loaded}, w);
        check({tag, "_pending"},  exp_q.size(), 32'd0);
    endtask

    task automatic push_good();
        exp_q.push_back(wr_t'{addr: 8'h00, data: 32'h00100013});
        exp_q.push_back(wr_t'{addr: 8'h01, data: 32'h00500093});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b1;

        // Bytes offered while idle are not accepted.
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        repeat (3) @(negedge clk);
        check("idle_rx_ready", {31'd0, rx_ready}, 32'd0);
        rx_valid = 1'b0;
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Good load.
        pulse_start();
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_hold", {31'd0, cpu_hold}, 32'd1);
        push_good();
        send_range(good_fr, 0, 10, 0);
        check_status("good", 1'b1, 1'b0, 1'b0, 2);

        // Same frame with gaps and an ignored start pulse mid-DATA.
        pulse_start();
        check("restart_done", {31'd0, done}, 32'd0);
        check("restart_hold", {31'd0, cpu_hold}, 32'd1);
        push_good();
        send_range(good_fr, 0, 4, 3);
        pulse_start();
        check("midstart_busy", {31'd0, busy}, 32'd1);
        check("midstart_words", {23'd0, words_loaded}, 32'd0);
        send_range(good_fr, 5, 10, 3);
        check_status("gaps", 1'b1, 1'b0, 1'b0, 2);

        // Bad checksum: writes still happen, CPU stays held.
        pulse_start();
        push_good();
        send_range(bad_fr, 0, 10, 1);
        check_status("badcsum", 1'b0, 1'b1, 1'b1, 2);

        // Zero and oversize lengths are rejected before any write.
        pulse_start();
        send_range(zero_fr, 0, 1, 0);
        check_status("len0", 1'b0, 1'b1, 1'b1, 0);
        pulse_start();
        send_range(big_fr, 0, 1, 0);
        check_status("len257", 1'b0, 1'b1, 1'b1, 0);

        // Reset in the middle of the data phase.
        pulse_start();
        send_range(good_fr, 0, 4, 0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        reset = 1'b1;
        pulse_start();
        push_good();
        send_range(good_fr, 0, 10, 0);
        check_status("afterrst", 1'b1, 1'b0, 1'b0, 2);

        // Reload after a completed load.
        pulse_start();
        check("reload_hold", {31'd0, cpu_hold}, 32'd1);
        check("reload_done", {31'd0, done}, 32'd0);
        exp_q.push_back(wr_t'{addr: 8'h00, data: 32'h00100013});
        send_range(one_fr, 0, 6, 0);
        check_status("reload", 1'b1, 1'b0, 1'b0, 1);

        repeat (4) @(negedge clk);
        check("final_pending", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
